forwarding_hazard_unit: RTL and testbench

//  Parametrised successor to the EX/ID forwarding logic. Generates per-operand forwarding selects

---
 rtl/forwarding_hazard_unit.sv | 119 +++++++++++
 tb/tb_forwarding_hazard_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding selects, load-use stall detection and a scoreboard for one
// multi-cycle multiply/divide unit, sitting beside the ID/EX pipeline registers.
module forwarding_hazard_unit #(
   parameter  int NUM_SRC    = 2,
   parameter  int FWD_STAGES = 2,
   parameter  int MD_LATENCY = 4,
   parameter  int AW         = 5,
   localparam int SELW       = $clog2(FWD_STAGES + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [FWD_STAGES-1:0]     stg_regwrite,
   input  logic [FWD_STAGES*AW-1:0]  stg_regdst,
   input  logic [NUM_SRC*AW-1:0]     ex_src,
   input  logic [NUM_SRC*AW-1:0]     id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic                      id_ex_memread,
   input  logic [AW-1:0]             id_ex_regdst,
   input  logic                      md_start,
   input  logic [AW-1:0]             md_regdst,
   input  logic                      id_is_md,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel,
   output logic                      stall,
   output logic                      bubble,
   output logic                      md_busy,
   output logic                      md_result_valid,
   output logic [AW-1:0]             md_dst_q
);

   localparam int CNTW = $clog2(MD_LATENCY);

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_BUSY,
      MD_DONE
   } md_state_t;

   md_state_t       state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [AW-1:0]   md_dst_d;
   logic            luse_match, luse;
   logic            md_match, mdh;

   // Scan from the oldest stage down so the youngest matching producer wins.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_regwrite[k] &&
                (stg_regdst[k*AW +: AW] == ex_src[i*AW +: AW]) &&
                (ex_src[i*AW +: AW] != '0)) begin
               fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
            end
         end
      end
   end

   always_comb begin
      luse_match = 1'b0;
      md_match   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_src_used[i] && (id_src[i*AW +: AW] == id_ex_regdst)) begin
            luse_match = 1'b1;
         end
         if (id_src_used[i] && (id_src[i*AW +: AW] == md_dst_q)) begin
            md_match = 1'b1;
         end
      end
      luse = id_ex_memread && (id_ex_regdst != '0) && luse_match;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         md_dst_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_dst_q <= md_dst_d;
      end
   end

   // A start in DONE is taken like one in IDLE, so back-to-back ops leave no gap.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_dst_d = md_dst_q;
      case (state_q)
         MD_IDLE, MD_DONE: begin
            if (md_start) begin
               state_d  = MD_BUSY;
               cnt_d    = CNTW'(MD_LATENCY - 1);
               md_dst_d = md_regdst;
            end else if (state_q == MD_DONE) begin
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               state_d = MD_DONE;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   // The result is forwardable in DONE, so only BUSY can raise the MD hazard.
   always_comb begin
      md_busy         = (state_q != MD_IDLE);
      md_result_valid = (state_q == MD_DONE);
      mdh             = (state_q == MD_BUSY) &&
                        (id_is_md || (md_match && (md_dst_q != '0)));
      stall           = luse || mdh;
      bubble          = stall;
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed and randomized checks of forwarding_hazard_unit against a
// cycle-indexed reference model of forwarding, load-use and MD timing.
module tb_forwarding_hazard_unit;

   localparam int NUM_SRC    = 2;
   localparam int FWD_STAGES = 2;
   localparam int MD_LATENCY = 4;
   localparam int AW         = 5;
   localparam int SELW       = $clog2(FWD_STAGES + 1);

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [FWD_STAGES-1:0]    stg_regwrite;
   logic [FWD_STAGES*AW-1:0] stg_regdst;
   logic [NUM_SRC*AW-1:0]    ex_src;
   logic [NUM_SRC*AW-1:0]    id_src;
   logic [NUM_SRC-1:0]       id_src_used;
   logic                     id_ex_memread;
   logic [AW-1:0]            id_ex_regdst;
   logic                     md_start;
   logic [AW-1:0]            md_regdst;
   logic                     id_is_md;
   logic [NUM_SRC*SELW-1:0]  fwd_sel;
   logic                     stall;
   logic                     bubble;
   logic                     md_busy;
   logic                     md_result_valid;
   logic [AW-1:0]            md_dst_q;

   forwarding_hazard_unit #(
      .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .MD_LATENCY(MD_LATENCY), .AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .stg_regwrite(stg_regwrite), .stg_regdst(stg_regdst),
      .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
      .id_ex_memread(id_ex_memread), .id_ex_regdst(id_ex_regdst),
      .md_start(md_start), .md_regdst(md_regdst), .id_is_md(id_is_md),
      .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
      .md_busy(md_busy), .md_result_valid(md_result_valid), .md_dst_q(md_dst_q)
   );

   always #5 clk = ~clk;

   int tests    = 0;
   int failures = 0;

   // Model: an accepted start at edge s makes the unit busy in cycles s..s+L-2
   // and ready in cycle s+L-1, where cycle t is the interval after edge t.
   int            cyc       = 0;
   bit            act       = 1'b0;
   int            start_cyc = 0;
   logic [AW-1:0] mdl_dst   = '0;

   function automatic bit mdl_busy_state();
      return act && (cyc < start_cyc + MD_LATENCY - 1);
   endfunction

   function automatic bit mdl_done();
      return act && (cyc == start_cyc + MD_LATENCY - 1);
   endfunction

   function automatic logic [AW-1:0] src_of(logic [NUM_SRC*AW-1:0] v, int i);
      return v[i*AW +: AW];
   endfunction

   task automatic model_reset();
      act     = 1'b0;
      mdl_dst = '0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(bit rnd);
      if (rnd) begin
         stg_regwrite  = FWD_STAGES'($urandom);
         for (int k = 0; k < FWD_STAGES; k++) stg_regdst[k*AW +: AW] = AW'($urandom_range(0, 7));
         for (int i = 0; i < NUM_SRC; i++) begin
            ex_src[i*AW +: AW] = AW'($urandom_range(0, 7));
            id_src[i*AW +: AW] = AW'($urandom_range(0, 7));
         end
         id_src_used   = NUM_SRC'($urandom);
         id_ex_memread = ($urandom_range(0, 2) == 0);
         id_ex_regdst  = AW'($urandom_range(0, 7));
         md_start      = ($urandom_range(0, 3) == 0);
         md_regdst     = AW'($urandom_range(0, 7));
         id_is_md      = ($urandom_range(0, 4) == 0);
      end else begin
         stg_regwrite  = '0;
         stg_regdst    = '0;
         ex_src        = '0;
         id_src        = '0;
         id_src_used   = '0;
         id_ex_memread = 1'b0;
         id_ex_regdst  = '0;
         md_start      = 1'b0;
         md_regdst     = '0;
         id_is_md      = 1'b0;
      end
   endtask

   task automatic checkOutput(bit wait_edge);
      logic [SELW-1:0] e_sel;
      bit              e_luse, e_mdh;
      if (wait_edge) @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
         e_sel = '0;
         for (int k = 0; k < FWD_STAGES; k++) begin
            if (e_sel == '0 && stg_regwrite[k] && src_of(ex_src, i) != '0 &&
                stg_regdst[k*AW +: AW] == src_of(ex_src, i)) e_sel = SELW'(k + 1);
         end
         chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*SELW +: SELW]), 32'(e_sel));
      end
      e_luse = 1'b0;
      e_mdh  = id_is_md;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_src_used[i] && src_of(id_src, i) == id_ex_regdst) e_luse = 1'b1;
         if (id_src_used[i] && src_of(id_src, i) == mdl_dst && mdl_dst != '0) e_mdh = 1'b1;
      end
      e_luse = e_luse && id_ex_memread && (id_ex_regdst != '0);
      e_mdh  = e_mdh && mdl_busy_state();
      chk("stall", 32'(stall), 32'(e_luse || e_mdh));
      chk("bubble", 32'(bubble), 32'(e_luse || e_mdh));
      chk("md_busy", 32'(md_busy), 32'(mdl_busy_state() || mdl_done()));
      chk("md_result_valid", 32'(md_result_valid), 32'(mdl_done()));
      chk("md_dst_q", 32'(md_dst_q), 32'(mdl_dst));
   endtask

   task automatic tick();
      bit accept;
      @(posedge clk);
      accept = md_start && rst_n && !mdl_busy_state();
      cyc++;
      if (!rst_n) begin
         model_reset();
      end else if (accept) begin
         act       = 1'b1;
         start_cyc = cyc;
         mdl_dst   = md_regdst;
      end
      #1;
   endtask

   initial begin
      bit restarted;

      // reset state
      applyStimulus(0);
      checkOutput(1);
      tick();
      rst_n = 1'b1;

      // youngest stage wins, then the older stage alone
      applyStimulus(0);
      stg_regwrite = 2'b11;
      stg_regdst   = {5'd5, 5'd5};
      ex_src       = {5'd0, 5'd5};
      checkOutput(1);
      tick();
      applyStimulus(0);
      stg_regwrite = 2'b10;
      stg_regdst   = {5'd5, 5'd5};
      ex_src       = {5'd5, 5'd5};
      checkOutput(1);
      tick();

      // register 0 never forwards
      applyStimulus(0);
      stg_regwrite = 2'b11;
      checkOutput(1);
      tick();

      // load-use on operand 1, then the same with operand 1 unused
      applyStimulus(0);
      id_ex_memread = 1'b1;
      id_ex_regdst  = 5'd8;
      id_src        = {5'd8, 5'd2};
      id_src_used   = 2'b10;
      checkOutput(1);
      tick();
      id_src_used   = 2'b01;
      checkOutput(1);
      tick();

      // single MD op to r3 with a dependent ID instruction
      applyStimulus(0);
      md_start  = 1'b1;
      md_regdst = 5'd3;
      checkOutput(1);
      tick();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(0);
         id_src      = {5'd0, 5'd3};
         id_src_used = 2'b01;
         checkOutput(1);
         tick();
      end

      // MD in ID stalls until DONE; restart during DONE
      applyStimulus(0);
      md_start  = 1'b1;
      md_regdst = 5'd4;
      checkOutput(1);
      tick();
      restarted = 1'b0;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(0);
         id_is_md = 1'b1;
         if (mdl_done() && !restarted) begin
            md_start  = 1'b1;
            md_regdst = 5'd6;
            restarted = 1'b1;
         end
         checkOutput(1);
         tick();
      end
      chk("restart_seen", 32'(restarted), 32'd1);

      // async reset in BUSY, then normal operation
      applyStimulus(0);
      md_start  = 1'b1;
      md_regdst = 5'd9;
      tick();
      applyStimulus(0);
      id_src      = {5'd9, 5'd9};
      id_src_used = 2'b11;
      checkOutput(1);
      rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput(0);
      tick();
      checkOutput(1);
      rst_n = 1'b1;
      tick();
      applyStimulus(0);
      md_start  = 1'b1;
      md_regdst = 5'd10;
      checkOutput(1);
      tick();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(0);
         id_src      = {5'd10, 5'd0};
         id_src_used = 2'b10;
         checkOutput(1);
         tick();
      end

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         applyStimulus(1);
         checkOutput(1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
